// File: rtl/game_flow_fsm.sv
// Top-level game sequencer: tracks world, level and lives, steps through the
// banner states and pulses level_load whenever play (re)starts.
module game_flow_fsm #(
    parameter int LEVELS_PER_WORLD = 4,
    parameter int NUM_WORLDS       = 3,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 9,
    parameter int HOLD_CYCLES      = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       level_complete,
    input  logic       player_died,
    output logic [2:0] game_status,
    output logic [2:0] world,
    output logic [2:0] level,
    output logic [3:0] lives,
    output logic       level_load
);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_LEVEL_INC = 3'd2,
        ST_WORLD_INC = 3'd3,
        ST_LIFE_LOST = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_GAME_WON  = 3'd6
    } state_t;

    localparam logic [2:0]  LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
    localparam logic [2:0]  LAST_WORLD = 3'(NUM_WORLDS - 1);
    localparam logic [3:0]  INIT_LIVES = 4'(START_LIVES);
    localparam logic [3:0]  CEIL_LIVES = 4'(MAX_LIVES);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);

    state_t      state_r, state_s;
    logic [2:0]  world_r, world_s;
    logic [2:0]  level_r, level_s;
    logic [3:0]  lives_r, lives_s;
    logic        level_load_r, level_load_s;
    logic [31:0] hold_cnt_r, hold_cnt_s;
    logic        start_q_r;
    logic        start_edge_s;

    // Rising edge of the button; history resets high so a held button is not an edge
    assign start_edge_s = start_btn & ~start_q_r;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_START;
            world_r      <= 3'd0;
            level_r      <= 3'd0;
            lives_r      <= INIT_LIVES;
            level_load_r <= 1'b0;
            hold_cnt_r   <= 32'd0;
            start_q_r    <= 1'b1;
        end else begin
            state_r      <= state_s;
            world_r      <= world_s;
            level_r      <= level_s;
            lives_r      <= lives_s;
            level_load_r <= level_load_s;
            hold_cnt_r   <= hold_cnt_s;
            start_q_r    <= start_btn;
        end
    end

    // Next-state, progression bookkeeping and level_load generation
    always_comb begin
        state_s      = state_r;
        world_s      = world_r;
        level_s      = level_r;
        lives_s      = lives_r;
        level_load_s = 1'b0;
        hold_cnt_s   = 32'd0;
        case (state_r)
            ST_START: begin
                if (start_edge_s) begin
                    state_s      = ST_PLAYING;
                    level_load_s = 1'b1;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_PLAYING: begin
                // The reload cycle ignores inputs so a stale level_complete is not re-counted
                if (level_load_r) begin
                    state_s = ST_PLAYING;
                end else if (level_complete) begin
                    if (level_r < LAST_LEVEL) begin
                        state_s = ST_LEVEL_INC;
                        level_s = level_r + 3'd1;
                    end else if (world_r < LAST_WORLD) begin
                        state_s = ST_WORLD_INC;
                        level_s = 3'd0;
                        world_s = world_r + 3'd1;
                        if (lives_r < CEIL_LIVES) begin
                            lives_s = lives_r + 4'd1;
                        end else begin
                            lives_s = CEIL_LIVES;
                        end
                    end else begin
                        state_s = ST_GAME_WON;
                    end
                end else if (player_died) begin
                    if (lives_r > 4'd1) begin
                        state_s = ST_LIFE_LOST;
                        lives_s = lives_r - 4'd1;
                    end else begin
                        state_s = ST_GAME_OVER;
                        lives_s = 4'd0;
                    end
                end else begin
                    state_s = ST_PLAYING;
                end
            end
            ST_LEVEL_INC, ST_WORLD_INC, ST_LIFE_LOST: begin
                if (hold_cnt_r >= HOLD_LAST) begin
                    state_s      = ST_PLAYING;
                    level_load_s = 1'b1;
                    hold_cnt_s   = 32'd0;
                end else begin
                    hold_cnt_s = hold_cnt_r + 32'd1;
                end
            end
            ST_GAME_OVER, ST_GAME_WON: begin
                if (start_edge_s) begin
                    state_s = ST_START;
                    world_s = 3'd0;
                    level_s = 3'd0;
                    lives_s = INIT_LIVES;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_START;
                world_s = 3'd0;
                level_s = 3'd0;
                lives_s = INIT_LIVES;
            end
        endcase
    end

    assign game_status = state_r;
    assign world       = world_r;
    assign level       = level_r;
    assign lives       = lives_r;
    assign level_load  = level_load_r;

endmodule
